// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
//   Y86-64 memory stage. Sits between the M pipe register and the W pipe
//   register. Decodes M_icode_i into a data-memory read or write, runs a
//   req/ack handshake on the data-memory port, and returns the loaded value
//   and final stage status. While an access is outstanding, m_busy_o asks the
//   hazard unit to stall F/D/E/M (and bubble W). Forwarding taps m_valM_o.
//
//   Optional feature (compile-time macro DMEM_TIMEOUT_EN):
//     abort an unacknowledged request after TIMEOUT_CYCLES cycles of req
//     and report SADR. Without the macro a request waits for ack forever.
//
// Ports
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   M_stat_i/M_icode_i      status and icode from the M pipe register
//   M_valE_i/M_valA_i       effective address / store data or stack pointer
//   W_stall_i               W register stalled; instruction may not leave M
//   dmem_req_o/we_o         request valid / 1 = write
//   dmem_addr_o/wdata_o     byte address / write data
//   dmem_ack_i/rdata_i/err_i  completion, read data, invalid address
//   m_valM_o/m_stat_o       loaded value / stage status
//   m_busy_o                access in flight (stall request)
// ---------------------------------------------------------------------------
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_W      = 7
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  M_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] M_valA_i,
  input  logic        W_stall_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic        m_busy_o
);

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] valm_q, valm_d;
  logic        err_q, err_d;
  logic        is_read, is_write, mem_op;
  logic        req;

  // Instruction decode.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    unique case (M_icode_i)
      IMRMOVQ, IPOPQ, IRET:   is_read  = 1'b1;
      IRMMOVQ, IPUSHQ, ICALL: is_write = 1'b1;
      default: ;
    endcase
  end

  // Bubbles and faulted instructions never touch memory.
  assign mem_op = (is_read | is_write) & (M_stat_i == SAOK);

  // Stack pops read through the old stack pointer carried in valA.
  assign dmem_addr_o  = (M_icode_i == IPOPQ || M_icode_i == IRET) ? M_valA_i : M_valE_i;
  assign dmem_wdata_o = M_valA_i;
  assign dmem_we_o    = is_write;

`ifdef DMEM_TIMEOUT_EN
  // count holds the number of cycles req has been high without ack, the
  // issuing IDLE cycle included, so req is high at most TIMEOUT_CYCLES cycles.
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] count;
  logic                 timeout;

  assign timeout = (count == TIMEOUT_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (state == ST_IDLE && state_nxt == ST_WAIT) begin
      count <= TIMEOUT_W'(1);
    end else if (state == ST_WAIT && state_nxt == ST_WAIT) begin
      count <= count + TIMEOUT_W'(1);
    end else begin
      count <= '0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_W'(TIMEOUT_CYCLES);
`endif

  // Next-state and capture logic.
  always_comb begin
    state_nxt = state;
    valm_d    = valm_q;
    err_d     = err_q;
    req       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Zero-cycle issue: the request goes out in the cycle the
        // instruction arrives in M.
        req = mem_op;
        if (mem_op) begin
          if (dmem_ack_i) begin
            state_nxt = ST_DONE;
            valm_d    = is_read ? dmem_rdata_i : 64'd0;
            err_d     = dmem_err_i;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Inputs are frozen by the stall, so addr/we/wdata stay stable.
        req = 1'b1;
        if (dmem_ack_i) begin
          state_nxt = ST_DONE;
          valm_d    = is_read ? dmem_rdata_i : 64'd0;
          err_d     = dmem_err_i;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (timeout) begin
          state_nxt = ST_DONE;
          valm_d    = 64'd0;
          err_d     = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        // Result is presented until W accepts the instruction; no re-issue.
        if (!W_stall_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= ST_IDLE;
      valm_q <= 64'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      valm_q <= valm_d;
      err_q  <= err_d;
    end
  end

  // Outputs are forced low while reset is asserted so an in-flight request
  // drops immediately rather than at the next edge.
  assign dmem_req_o = rst_n_i & req;
  assign m_busy_o   = rst_n_i & mem_op & (state != ST_DONE);
  assign m_valM_o   = (rst_n_i && state == ST_DONE) ? valm_q : 64'd0;
  assign m_stat_o   = !rst_n_i                     ? 3'd0 :
                      (state == ST_DONE && err_q)  ? SADR : M_stat_i;

endmodule
